// File: rtl/stage_pkg.sv
// Shared types and width helpers for the stage-4 accumulator slice.
// Holds the stage-4 FSM state enum and the helper that sizes beat counters.
// No logic; imported by stage4_accum and its datapath.
package stage_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } stage4_state_t;

   // Bits needed to hold a beat count in the range 0..max_beats inclusive.
   function automatic int stage4_cnt_w(input int unsigned max_beats);
      return $clog2(max_beats + 1);
   endfunction

   localparam int STAGE4_CNT_W_DEFAULT = stage4_cnt_w(16);

endpackage

// File: rtl/stage4_acc_add.sv
// Purpose: next-value datapath for the stage-4 accumulator (load, add, carry, optional clamp).
// Latency: purely combinational. Backpressure: none; the caller decides when to commit.
// Ports: i_load selects a fresh load of i_sum; otherwise o_acc = i_acc + i_sum with
//        o_ovf = i_ovf | carry-out. Macro STAGE4_SATURATE_EN clamps to all-ones on overflow.
module stage4_acc_add #(
   parameter int SUM_W = 13,
   parameter int ACC_W = 24
) (
   input  logic             i_load,
   input  logic [ACC_W-1:0] i_acc,
   input  logic             i_ovf,
   input  logic [SUM_W-1:0] i_sum,
   output logic [ACC_W-1:0] o_acc,
   output logic             o_ovf
);

   logic [ACC_W:0] w_sum_ext;
   logic           w_carry;

   // One extra bit captures the carry that leaves the accumulator width.
   assign w_sum_ext = {1'b0, i_acc} + (ACC_W+1)'(i_sum);
   assign w_carry   = w_sum_ext[ACC_W];

   always_comb begin
      o_acc = w_sum_ext[ACC_W-1:0];
      o_ovf = i_ovf | w_carry;
      if (i_load) begin
         o_acc = ACC_W'(i_sum);
         o_ovf = 1'b0;
      end else begin
`ifdef STAGE4_SATURATE_EN
         // Once the group has overflowed the value stays pinned at all-ones.
         if (i_ovf | w_carry) begin
            o_acc = '1;
         end
`endif
      end
   end

endmodule

// File: rtl/stage4_accum.sv
// Purpose: folds groups of stage-3 sums into one accumulated result per group (IDLE/ACCUM/HOLD FSM).
// Latency: result valid one cycle after the accepting edge of the closing beat.
// Backpressure: in HOLD, in_ready follows out_ready so a new group can start on the take edge.
// Ports: in_valid/in_ready/in_sum/in_last beat input; out_valid/out_ready/out_acc/out_count/
//        out_overflow result output. Build macro STAGE4_SATURATE_EN selects clamping over wrap.
module stage4_accum
   import stage_pkg::*;
#(
   parameter int STAGE_3_OUT_BIT_WIDTH = 13,
   parameter int ACC_BIT_WIDTH         = 24,
   parameter int MAX_BEATS             = 16
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [STAGE_3_OUT_BIT_WIDTH-1:0]   in_sum,
   input  logic                               in_last,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [ACC_BIT_WIDTH-1:0]           out_acc,
   output logic [$clog2(MAX_BEATS+1)-1:0]     out_count,
   output logic                               out_overflow
);

   localparam int               CNT_W   = stage4_cnt_w(MAX_BEATS);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

   stage4_state_t            r_state;
   stage4_state_t            w_state_nxt;
   logic [ACC_BIT_WIDTH-1:0] r_acc;
   logic [CNT_W-1:0]         r_cnt;
   logic                     r_ovf;

   logic                     w_load;
   logic                     w_upd;
   logic                     w_close;
   logic [CNT_W-1:0]         w_cnt_nxt;
   logic [ACC_BIT_WIDTH-1:0] w_acc_nxt;
   logic                     w_ovf_nxt;

   assign in_ready     = (r_state != ST_HOLD) | out_ready;
   assign out_valid    = (r_state == ST_HOLD);
   assign out_acc      = r_acc;
   assign out_count    = r_cnt;
   assign out_overflow = r_ovf;

   assign w_cnt_nxt = w_load ? CNT_W'(1) : r_cnt + CNT_W'(1);
   // A group closes on in_last or when it reaches the beat cap; only meaningful when w_upd.
   assign w_close   = in_last | (w_cnt_nxt == MAX_CNT);

   stage4_acc_add #(
      .SUM_W (STAGE_3_OUT_BIT_WIDTH),
      .ACC_W (ACC_BIT_WIDTH)
   ) u_add (
      .i_load (w_load),
      .i_acc  (r_acc),
      .i_ovf  (r_ovf),
      .i_sum  (in_sum),
      .o_acc  (w_acc_nxt),
      .o_ovf  (w_ovf_nxt)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_upd       = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (in_valid) begin
               w_load      = 1'b1;
               w_upd       = 1'b1;
               w_state_nxt = w_close ? ST_HOLD : ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (in_valid) begin
               w_upd       = 1'b1;
               w_state_nxt = w_close ? ST_HOLD : ST_ACCUM;
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               // Result taken; a beat arriving on the same edge opens the next group.
               if (in_valid) begin
                  w_load      = 1'b1;
                  w_upd       = 1'b1;
                  w_state_nxt = w_close ? ST_HOLD : ST_ACCUM;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_upd) begin
            r_acc <= w_acc_nxt;
            r_cnt <= w_cnt_nxt;
            r_ovf <= w_ovf_nxt;
         end
      end
   end

endmodule

// File: tb/tb_stage4_accum.sv
// Bench for stage4_accum: directed cases plus a randomized run against a group-level model.
// Two instances share stimulus: default widths, and a 13-bit accumulator for overflow cases.
module tb_stage4_accum;

`ifdef STAGE4_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_last;
   logic        out_ready;
   logic [12:0] in_sum;

   logic        in_ready, out_valid, out_overflow;
   logic [23:0] out_acc;
   logic [4:0]  out_count;

   logic        in_ready13, out_valid13, out_ovf13;
   logic [12:0] out_acc13;
   logic [4:0]  out_count13;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   stage4_accum #(.STAGE_3_OUT_BIT_WIDTH(13), .ACC_BIT_WIDTH(24), .MAX_BEATS(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
      .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
      .out_count(out_count), .out_overflow(out_overflow));

   stage4_accum #(.STAGE_3_OUT_BIT_WIDTH(13), .ACC_BIT_WIDTH(13), .MAX_BEATS(16)) dut13 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready13), .in_sum(in_sum),
      .in_last(in_last), .out_valid(out_valid13), .out_ready(out_ready), .out_acc(out_acc13),
      .out_count(out_count13), .out_overflow(out_ovf13));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: fold one more beat into a running group total of width w.
   function automatic logic [64:0] fold(input logic [63:0] acc, input logic [63:0] b,
                                        input int w, input bit ovf);
      logic [63:0] mx;
      logic [63:0] s;
      mx = (64'd1 << w) - 64'd1;
      s  = acc + b;
      if (s > mx) begin
         ovf = 1'b1;
         s   = SAT ? mx : (s & mx);
      end
      return {ovf, s};
   endfunction

   task automatic beat(input int s, input bit last);
      @(negedge clk);
      in_valid = 1'b1;
      in_sum   = 13'(s);
      in_last  = last;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      logic [63:0] q_acc24[$], q_acc13[$], q_cnt[$];
      bit          q_ovf24[$], q_ovf13[$];
      logic [63:0] g24, g13;
      logic [64:0] r;
      bit          o24, o13;
      int          gcnt, closed, done, cycles;

      rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_last = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_ready", 64'(in_ready), 64'd1);
      check("rst_acc", 64'(out_acc), 64'd0);
      check("rst_cnt", 64'(out_count), 64'd0);
      check("rst_ovf", 64'(out_overflow), 64'd0);
      rst = 1'b0;

      // Basic three-beat group
      beat(100, 1'b0); beat(200, 1'b0); beat(300, 1'b1);
      check("g1_valid", 64'(out_valid), 64'd1);
      check("g1_acc", 64'(out_acc), 64'd600);
      check("g1_cnt", 64'(out_count), 64'd3);
      check("g1_ovf", 64'(out_overflow), 64'd0);
      @(posedge clk); #1;
      check("g1_one_cycle", 64'(out_valid), 64'd0);

      // Held result under backpressure, then take with a same-edge new beat
      @(negedge clk); out_ready = 1'b0;
      beat(1, 1'b0); beat(2, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_sum = 13'd99; in_last = 1'b1;
         #1;
         check("hold_in_ready", 64'(in_ready), 64'd0);
         check("hold_valid", 64'(out_valid), 64'd1);
         check("hold_acc", 64'(out_acc), 64'd3);
         check("hold_cnt", 64'(out_count), 64'd2);
         @(posedge clk);
      end
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; in_sum = 13'd7; in_last = 1'b0;
      #1;
      check("pass_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("pass_valid_drop", 64'(out_valid), 64'd0);
      beat(8, 1'b1);
      check("pass_acc", 64'(out_acc), 64'd15);
      check("pass_cnt", 64'(out_count), 64'd2);
      @(posedge clk); #1;

      // Forced close at the beat cap
      for (int i = 0; i < 16; i++) begin
         beat(1, 1'b0);
         if (i == 14) check("cap_not_early", 64'(out_valid), 64'd0);
      end
      check("cap_valid", 64'(out_valid), 64'd1);
      check("cap_acc", 64'(out_acc), 64'd16);
      check("cap_cnt", 64'(out_count), 64'd16);
      @(posedge clk); #1;

      // Overflow in the narrow accumulator
      beat(8191, 1'b0); beat(2, 1'b1);
      check("ovf13_valid", 64'(out_valid13), 64'd1);
      check("ovf13_acc", 64'(out_acc13), SAT ? 64'd8191 : 64'd1);
      check("ovf13_flag", 64'(out_ovf13), 64'd1);
      check("ovf24_acc", 64'(out_acc), 64'd8193);
      check("ovf24_flag", 64'(out_overflow), 64'd0);
      @(posedge clk); #1;

      // Reset mid-group discards the partial result
      beat(5, 1'b0); beat(6, 1'b0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      check("mrst_cnt", 64'(out_count), 64'd0);
      check("mrst_acc", 64'(out_acc), 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("mrst_no_valid", 64'(out_valid), 64'd0);
      end
      beat(5, 1'b0); beat(5, 1'b1);
      check("mrst_acc2", 64'(out_acc), 64'd10);
      check("mrst_cnt2", 64'(out_count), 64'd2);
      @(posedge clk); #1;

      // Random gaps over 1000 groups, both accumulator widths scored
      gcnt = 0; closed = 0; done = 0; cycles = 0;
      g24 = '0; g13 = '0; o24 = 1'b0; o13 = 1'b0;
      while (done < 1000 && cycles < 60000) begin
         @(negedge clk);
         cycles++;
         in_valid  = (closed < 1000) && ($urandom_range(0, 3) != 0);
         in_sum    = 13'($urandom_range(0, 8191));
         in_last   = ($urandom_range(0, 5) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (out_valid && out_ready) begin
            if (q_acc24.size() == 0) begin
               check("rnd_spurious_result", 64'(out_valid), 64'd0);
            end else begin
               check("rnd_acc24", 64'(out_acc), q_acc24.pop_front());
               check("rnd_ovf24", 64'(out_overflow), 64'(q_ovf24.pop_front()));
               check("rnd_acc13", 64'(out_acc13), q_acc13.pop_front());
               check("rnd_ovf13", 64'(out_ovf13), 64'(q_ovf13.pop_front()));
               check("rnd_cnt", 64'(out_count), q_cnt.pop_front());
               check("rnd_valid13", 64'(out_valid13), 64'd1);
               done++;
            end
         end
         if (in_valid && in_ready) begin
            if (gcnt == 0) begin
               g24 = 64'(in_sum); g13 = 64'(in_sum); o24 = 1'b0; o13 = 1'b0;
            end else begin
               r = fold(g24, 64'(in_sum), 24, o24); o24 = r[64]; g24 = r[63:0];
               r = fold(g13, 64'(in_sum), 13, o13); o13 = r[64]; g13 = r[63:0];
            end
            gcnt++;
            if (in_last || gcnt == 16) begin
               q_acc24.push_back(g24); q_ovf24.push_back(o24);
               q_acc13.push_back(g13); q_ovf13.push_back(o13);
               q_cnt.push_back(64'(gcnt));
               gcnt = 0;
               closed++;
            end
         end
      end
      in_valid = 1'b0;
      check("rnd_groups_done", 64'(done), 64'd1000);
      check("rnd_queue_empty", 64'(q_acc24.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
